spec_free_list: RTL and testbench



---
 rtl/fabscalar_pkg.sv | 12 +
 rtl/spec_free_list_if.sv | 38 +++
 rtl/free_list_compact.sv | 24 ++
 rtl/spec_free_list.sv | 94 +++++++++
 tb/tb_spec_free_list.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fabscalar_pkg.sv
// Shared rename-stage sizing constants and tag/pointer types used by the map tables and free list.
package fabscalar_pkg;
  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_RMT            = 32;
  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int SIZE_FREE_LIST_LOG  = 6;

  typedef logic [SIZE_PHYSICAL_LOG-1:0]  phys_tag_t;
  typedef logic [SIZE_FREE_LIST_LOG-1:0] fl_ptr_t;
  typedef logic [SIZE_FREE_LIST_LOG:0]   fl_cnt_t;
endpackage

// File: rtl/spec_free_list_if.sv
// Rename/commit-facing bundle of the speculative free list.
interface spec_free_list_if;
  import fabscalar_pkg::*;

  logic      reqFreeReg_i;
  phys_tag_t freeReg0_o;
  phys_tag_t freeReg1_o;
  phys_tag_t freeReg2_o;
  phys_tag_t freeReg3_o;
  logic      freeListEmpty_o;
  logic      releasedValid0_i;
  logic      releasedValid1_i;
  logic      releasedValid2_i;
  logic      releasedValid3_i;
  phys_tag_t releasedPhyMap0_i;
  phys_tag_t releasedPhyMap1_i;
  phys_tag_t releasedPhyMap2_i;
  phys_tag_t releasedPhyMap3_i;
  logic      recoverFlag_i;
  fl_cnt_t   freeListCnt_o;
  logic      overflow_o;

  modport slave (
    input  reqFreeReg_i, recoverFlag_i,
    input  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    input  releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
    output freeListEmpty_o, freeListCnt_o, overflow_o
  );

  modport master (
    output reqFreeReg_i, recoverFlag_i,
    output releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
    output releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
    input  freeListEmpty_o, freeListCnt_o, overflow_o
  );
endinterface

// File: rtl/free_list_compact.sv
// Packs the valid release slots into consecutive lanes, lowest slot first.
module free_list_compact
  import fabscalar_pkg::*;
(
  input  logic [3:0] i_valid,
  input  phys_tag_t  i_tag [4],
  output phys_tag_t  o_tag [4],
  output logic [2:0] o_cnt
);

  always_comb begin
    logic [2:0] v_n;
    v_n   = '0;
    o_tag = '{default: '0};
    for (int k = 0; k < 4; k++) begin
      if (i_valid[k]) begin
        o_tag[v_n[1:0]] = i_tag[k];
        v_n             = v_n + 3'd1;
      end
    end
    o_cnt = v_n;
  end

endmodule

// File: rtl/spec_free_list.sv
// Speculative free list: circular buffer of free physical tags, 4 allocations and
// up to 4 releases per cycle, single-cycle recovery by rewinding head onto tail.
module spec_free_list
  import fabscalar_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  spec_free_list_if.slave  fl
);

  localparam fl_cnt_t FULL = fl_cnt_t'(SIZE_FREE_LIST);

  phys_tag_t r_buf [SIZE_FREE_LIST];
  fl_ptr_t   r_head;
  fl_ptr_t   r_tail;
  fl_cnt_t   r_cnt;
  logic      r_ovf;

  logic [3:0] w_rel_valid;
  phys_tag_t  w_rel_tag [4];
  phys_tag_t  w_cmp_tag [4];
  logic [2:0] w_n;
  logic       w_empty;
  logic       w_pop;
  fl_cnt_t    w_cnt_after_pop;
  fl_cnt_t    w_room;
  logic       w_ovf_evt;
  logic [2:0] w_nwr;
  fl_ptr_t    w_tail_next;

  assign w_rel_valid = {fl.releasedValid3_i, fl.releasedValid2_i,
                        fl.releasedValid1_i, fl.releasedValid0_i};
  assign w_rel_tag[0] = fl.releasedPhyMap0_i;
  assign w_rel_tag[1] = fl.releasedPhyMap1_i;
  assign w_rel_tag[2] = fl.releasedPhyMap2_i;
  assign w_rel_tag[3] = fl.releasedPhyMap3_i;

  free_list_compact u_compact (
    .i_valid (w_rel_valid),
    .i_tag   (w_rel_tag),
    .o_tag   (w_cmp_tag),
    .o_cnt   (w_n)
  );

  assign w_empty         = (r_cnt < fl_cnt_t'(4));
  assign w_pop           = fl.reqFreeReg_i && !w_empty && !fl.recoverFlag_i;
  assign w_cnt_after_pop = r_cnt - (w_pop ? fl_cnt_t'(4) : fl_cnt_t'(0));
  assign w_room          = FULL - w_cnt_after_pop;
  // Only the releases that fit are written; room is below 4 whenever this clips.
  assign w_ovf_evt       = (fl_cnt_t'(w_n) > w_room);
  assign w_nwr           = w_ovf_evt ? w_room[2:0] : w_n;
  assign w_tail_next     = r_tail + fl_ptr_t'(w_nwr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        r_buf[i] <= phys_tag_t'(SIZE_RMT + i);
      end
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= FULL;
      r_ovf  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < w_nwr) begin
          r_buf[r_tail + fl_ptr_t'(k)] <= w_cmp_tag[k];
        end
      end
      r_tail <= w_tail_next;
      // Recovery lands head on the post-release tail, returning every in-flight tag.
      if (fl.recoverFlag_i) begin
        r_head <= w_tail_next;
        r_cnt  <= FULL;
      end else begin
        if (w_pop) begin
          r_head <= r_head + fl_ptr_t'(4);
        end
        r_cnt <= w_cnt_after_pop + fl_cnt_t'(w_nwr);
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign fl.freeReg0_o      = r_buf[r_head];
  assign fl.freeReg1_o      = r_buf[r_head + fl_ptr_t'(1)];
  assign fl.freeReg2_o      = r_buf[r_head + fl_ptr_t'(2)];
  assign fl.freeReg3_o      = r_buf[r_head + fl_ptr_t'(3)];
  assign fl.freeListEmpty_o = w_empty;
  assign fl.freeListCnt_o   = r_cnt;
  assign fl.overflow_o      = r_ovf;

endmodule

// File: tb/tb_spec_free_list.sv
// Bench for spec_free_list: reference model of the free pool checked every cycle,
// plus hand-computed expectations at key points of the directed sequence.
module tb_spec_free_list;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spec_free_list_if fl();

  spec_free_list u_dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl)
  );

  // Reference model: pool of 64 slots, head/tail/count in plain integers.
  int mbuf [64];
  int mhead, mtail, mcnt;
  bit movf;
  bit mvalid = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int   after;
    bit   pop;
    int   tg [4];
    logic [3:0] v;
    if (reset) begin
      for (int i = 0; i < 64; i++) mbuf[i] = 32 + i;
      mhead  = 0;
      mtail  = 0;
      mcnt   = 64;
      movf   = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      v     = {fl.releasedValid3_i, fl.releasedValid2_i, fl.releasedValid1_i, fl.releasedValid0_i};
      tg[0] = fl.releasedPhyMap0_i;
      tg[1] = fl.releasedPhyMap1_i;
      tg[2] = fl.releasedPhyMap2_i;
      tg[3] = fl.releasedPhyMap3_i;
      pop   = fl.reqFreeReg_i && (mcnt >= 4) && !fl.recoverFlag_i;
      after = mcnt - (pop ? 4 : 0);
      for (int s = 0; s < 4; s++) begin
        if (v[s]) begin
          if (after < 64) begin
            mbuf[mtail] = tg[s];
            mtail = (mtail + 1) % 64;
            after++;
          end else begin
            movf = 1'b1;
          end
        end
      end
      if (fl.recoverFlag_i) begin
        mhead = mtail;
        mcnt  = 64;
      end else begin
        mhead = (mhead + (pop ? 4 : 0)) % 64;
        mcnt  = after;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("freeReg0", fl.freeReg0_o, mbuf[mhead]);
      chk("freeReg1", fl.freeReg1_o, mbuf[(mhead + 1) % 64]);
      chk("freeReg2", fl.freeReg2_o, mbuf[(mhead + 2) % 64]);
      chk("freeReg3", fl.freeReg3_o, mbuf[(mhead + 3) % 64]);
      chk("count",    fl.freeListCnt_o, mcnt);
      chk("empty",    fl.freeListEmpty_o, (mcnt < 4) ? 1 : 0);
      chk("overflow", fl.overflow_o, movf);
    end
  end

  task automatic set_in(input logic req, input logic [3:0] v,
                        input int t0, input int t1, input int t2, input int t3,
                        input logic rec);
    fl.reqFreeReg_i      = req;
    fl.releasedValid0_i  = v[0];
    fl.releasedValid1_i  = v[1];
    fl.releasedValid2_i  = v[2];
    fl.releasedValid3_i  = v[3];
    fl.releasedPhyMap0_i = 7'(t0);
    fl.releasedPhyMap1_i = 7'(t1);
    fl.releasedPhyMap2_i = 7'(t2);
    fl.releasedPhyMap3_i = 7'(t3);
    fl.recoverFlag_i     = rec;
  endtask

  task automatic drive(input logic req, input logic [3:0] v,
                       input int t0, input int t1, input int t2, input int t3,
                       input logic rec);
    @(posedge clk);
    #1;
    set_in(req, v, t0, t1, t2, t3, rec);
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
  endtask

  // Reset pulse with every other input active, which reset must override.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_in(1'b1, 4'b1111, 1, 2, 3, 4, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    set_in(1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_fr0", fl.freeReg0_o, 32);
    chk("rst_fr1", fl.freeReg1_o, 33);
    chk("rst_fr2", fl.freeReg2_o, 34);
    chk("rst_fr3", fl.freeReg3_o, 35);
    chk("rst_cnt", fl.freeListCnt_o, 64);
    chk("rst_empty", fl.freeListEmpty_o, 0);
    chk("rst_ovf", fl.overflow_o, 0);

    // Drain with 16 back-to-back requests.
    for (int c = 1; c <= 16; c++) begin
      drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
      @(negedge clk);
      if (c == 1) begin
        chk("drain1_fr0", fl.freeReg0_o, 32);
        chk("drain1_fr3", fl.freeReg3_o, 35);
      end
      if (c == 16) begin
        chk("drain16_fr0", fl.freeReg0_o, 92);
        chk("drain16_fr1", fl.freeReg1_o, 93);
        chk("drain16_fr2", fl.freeReg2_o, 94);
        chk("drain16_fr3", fl.freeReg3_o, 95);
      end
    end
    drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("drained_cnt", fl.freeListCnt_o, 0);
    chk("drained_empty", fl.freeListEmpty_o, 1);
    idle();
    @(negedge clk);
    chk("req17_cnt", fl.freeListCnt_o, 0);
    chk("req17_fr0", fl.freeReg0_o, 32);

    // Sparse release: slots 0 and 2 valid.
    drive(1'b0, 4'b0101, 40, 99, 50, 98, 1'b0);
    idle();
    @(negedge clk);
    chk("rel1010_cnt", fl.freeListCnt_o, 2);
    chk("rel1010_empty", fl.freeListEmpty_o, 1);
    drive(1'b0, 4'b0011, 60, 61, 0, 0, 1'b0);
    idle();
    @(negedge clk);
    chk("rel4_cnt", fl.freeListCnt_o, 4);
    chk("rel4_empty", fl.freeListEmpty_o, 0);
    chk("rel4_fr0", fl.freeReg0_o, 40);
    chk("rel4_fr1", fl.freeReg1_o, 50);
    chk("rel4_fr2", fl.freeReg2_o, 60);
    chk("rel4_fr3", fl.freeReg3_o, 61);

    // Allocate 8 then recover.
    do_reset();
    @(negedge clk);
    chk("rst2_cnt", fl.freeListCnt_o, 64);
    chk("rst2_fr0", fl.freeReg0_o, 32);
    drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    idle();
    @(negedge clk);
    chk("alloc8_cnt", fl.freeListCnt_o, 56);
    chk("alloc8_fr0", fl.freeReg0_o, 40);
    drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b1);
    idle();
    @(negedge clk);
    chk("recover_cnt", fl.freeListCnt_o, 64);
    chk("recover_fr0", fl.freeReg0_o, 32);

    // Allocate plus three releases per cycle, running tail past entry 63.
    do_reset();
    drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    drive(1'b1, 4'b1101, 0, 77, 1, 2, 1'b0);
    idle();
    @(negedge clk);
    chk("mix_cnt", fl.freeListCnt_o, 59);
    for (int i = 1; i <= 21; i++) begin
      drive(1'b1, 4'b1101, 3 * i, 77, 3 * i + 1, 3 * i + 2, 1'b0);
    end
    idle();
    @(negedge clk);
    chk("mix22_cnt", fl.freeListCnt_o, 38);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    end
    idle();
    @(negedge clk);
    chk("wrap_cnt", fl.freeListCnt_o, 2);
    chk("wrap_empty", fl.freeListEmpty_o, 1);
    chk("wrap_fr0", fl.freeReg0_o, 64);
    chk("wrap_fr1", fl.freeReg1_o, 65);

    // Release into a full list.
    do_reset();
    drive(1'b0, 4'b0001, 70, 0, 0, 0, 1'b0);
    idle();
    @(negedge clk);
    chk("ovf_set", fl.overflow_o, 1);
    chk("ovf_cnt", fl.freeListCnt_o, 64);
    chk("ovf_fr0", fl.freeReg0_o, 32);
    repeat (3) idle();
    @(negedge clk);
    chk("ovf_sticky", fl.overflow_o, 1);
    do_reset();
    @(negedge clk);
    chk("ovf_clear", fl.overflow_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
